// File: rtl/add_sequencer_pkg.sv
// Shared definitions for the adder sequencer: state encoding and nibble width.
package add_sequencer_pkg;

    // Width of one adder slice; operands are processed this many bits per cycle.
    localparam int unsigned NIB_W = 4;

    // Encoding is visible on the LEDs, so the values are fixed.
    typedef enum logic [1:0] {
        ST_LOAD_A = 2'b00,
        ST_LOAD_B = 2'b01,
        ST_ADD    = 2'b10,
        ST_SHOW   = 2'b11
    } state_e;

endpackage

// File: rtl/add_sequencer_if.sv
// Board-side bundle for the adder sequencer.
//   enter, acc_mode, sw         : push-button level, accumulate select, switch operand
//   a_out, b_out, sum_out       : captured operands and result for the 7-segment drivers
//   carry_out, busy, done       : MSB carry, ADD-in-progress flag, completion pulse
//   state_out                   : current controller state for the LEDs
// master = board/driver side, slave = sequencer.
interface add_sequencer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             enter;
    logic             acc_mode;
    logic [WIDTH-1:0] sw;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic [WIDTH-1:0] sum_out;
    logic             carry_out;
    logic             busy;
    logic             done;
    logic [1:0]       state_out;

    modport master (
        output enter, acc_mode, sw,
        input  a_out, b_out, sum_out, carry_out, busy, done, state_out
    );

    modport slave (
        input  enter, acc_mode, sw,
        output a_out, b_out, sum_out, carry_out, busy, done, state_out
    );
endinterface

// File: rtl/add_sequencer_nibble_adder.sv
// Combinational 4-bit adder slice, time-shared by the sequencer across nibbles.
//   a, b : nibble operands    cin  : carry in
//   s    : nibble sum         cout : carry out
module nibble_adder
    import add_sequencer_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout
);
    localparam int unsigned SUM_W = NIB_W + 1;

    assign {cout, s} = SUM_W'(a) + SUM_W'(b) + SUM_W'(cin);
endmodule

// File: rtl/add_sequencer.sv
// Operand-entry and nibble-serial add controller for the board adder datapath.
//   clock, reset : system clock, asynchronous active-high reset
//   bus (slave)  : switches/button in; operands, result, carry, status out
// A press loads A, then B, then the add runs one nibble per cycle (LSB first)
// on a single shared adder slice. In SHOW, a press either starts a new entry
// (loads A) or, in accumulate mode, chains the sum into A and adds sw at once.
module add_sequencer
    import add_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clock,
    input  logic           reset,
    add_sequencer_if.slave bus
);
    localparam int unsigned NIB   = WIDTH / NIB_W;
    localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               enter_q;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic               press_c;
    logic               last_nib_c;
    logic [NIB_W-1:0]   nib_a_c, nib_b_c, nib_s_c;
    logic               nib_cout_c;

    // Rising edge of the button: a held button is one press.
    assign press_c    = bus.enter & ~enter_q;
    assign last_nib_c = (idx_q == IDX_W'(NIB - 1));

    // Select the operand nibbles addressed by the current index.
    always_comb begin
        nib_a_c = '0;
        nib_b_c = '0;
        for (int n = 0; n < int'(NIB); n++) begin
            if (idx_q == IDX_W'(n)) begin
                nib_a_c = a_q[n*NIB_W +: NIB_W];
                nib_b_c = b_q[n*NIB_W +: NIB_W];
            end
        end
    end

    nibble_adder u_nibble_adder (
        .a    (nib_a_c),
        .b    (nib_b_c),
        .cin  (carry_q),
        .s    (nib_s_c),
        .cout (nib_cout_c)
    );

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_LOAD_A;
            idx_q   <= '0;
            carry_q <= 1'b0;
            enter_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            enter_q <= bus.enter;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        done_d  = 1'b0;

        case (state_q)
            ST_LOAD_A: begin
                if (press_c) begin
                    a_d     = bus.sw;
                    state_d = ST_LOAD_B;
                end
            end
            ST_LOAD_B: begin
                if (press_c) begin
                    b_d     = bus.sw;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                // Presses are deliberately ignored here.
                for (int n = 0; n < int'(NIB); n++) begin
                    if (idx_q == IDX_W'(n)) begin
                        sum_d[n*NIB_W +: NIB_W] = nib_s_c;
                    end
                end
                carry_d = nib_cout_c;
                idx_d   = IDX_W'(idx_q + 1'b1);
                if (last_nib_c) begin
                    cout_d  = nib_cout_c;
                    done_d  = 1'b1;
                    state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (press_c) begin
                    if (bus.acc_mode) begin
                        a_d     = sum_q;
                        b_d     = bus.sw;
                        idx_d   = '0;
                        carry_d = 1'b0;
                        state_d = ST_ADD;
                    end else begin
                        a_d     = bus.sw;
                        state_d = ST_LOAD_B;
                    end
                end
            end
            default: state_d = ST_LOAD_A;
        endcase
    end

    // busy is registered from the next state so it is high exactly while in ADD.
    assign busy_d = (state_d == ST_ADD);

    assign bus.a_out     = a_q;
    assign bus.b_out     = b_q;
    assign bus.sum_out   = sum_q;
    assign bus.carry_out = cout_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.state_out = state_q;

endmodule

// File: tb/tb_add_sequencer.sv
// Randomized scoreboard bench for add_sequencer (WIDTH = 8).
module tb_add_sequencer;
    localparam int W   = 8;
    localparam int NIB = W / 4;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    add_sequencer_if #(.WIDTH(W)) bus ();

    add_sequencer #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int done_cnt = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Transaction-level reference: operands, result and phase.
    typedef enum int {M_A, M_B, M_ADD, M_SHOW} mphase_e;
    typedef struct {
        int a;
        int b;
        int sum;
        int carry;
        int launch;
    } exp_t;

    exp_t    exp_q[$];
    mphase_e ms;
    int      ma, mb, msum, mc;

    function automatic int phase_code(input mphase_e p);
        case (p)
            M_A:     return 0;
            M_B:     return 1;
            M_ADD:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_reset();
        ms = M_A; ma = 0; mb = 0; msum = 0; mc = 0;
    endtask

    task automatic model_launch();
        int t;
        exp_t e;
        t      = ma + mb;
        msum   = t % 256;
        mc     = t / 256;
        e.a    = ma;
        e.b    = mb;
        e.sum  = msum;
        e.carry = mc;
        e.launch = cyc;
        exp_q.push_back(e);
        ms = M_ADD;
    endtask

    // Monitor: every completion pulse is matched against the oldest expected add.
    always @(negedge clock) begin
        if (!reset && bus.done) begin
            exp_t e;
            done_cnt++;
            check("done_has_pending", longint'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sum_out",   bus.sum_out,   e.sum);
                check("carry_out", bus.carry_out, e.carry);
                check("a_out@done", bus.a_out,    e.a);
                check("b_out@done", bus.b_out,    e.b);
                check("state@done", bus.state_out, 3);
                check("busy@done",  bus.busy,      0);
                check("done_latency", cyc - e.launch, NIB);
            end
        end
    end

    // mode 0: normal, 1: extra press during ADD, 2: return right after ADD entry.
    task automatic drive_press(input int v, input int acc, input int mode);
        int start;
        @(negedge clock);
        bus.sw       = W'(v);
        bus.acc_mode = acc[0];
        bus.enter    = 1'b1;
        @(negedge clock);
        bus.enter    = 1'b0;
        start = done_cnt;
        case (ms)
            M_A: begin ma = v; ms = M_B; end
            M_B: begin mb = v; model_launch(); end
            M_SHOW: begin
                if (acc != 0) begin ma = msum; mb = v; model_launch(); end
                else begin ma = v; ms = M_B; end
            end
            default: ;
        endcase
        check("a_out", bus.a_out, ma);
        check("b_out", bus.b_out, mb);
        check("state_out", bus.state_out, phase_code(ms));
        if (ms != M_ADD) check("sum_held", bus.sum_out, msum);
        else check("busy_in_add", bus.busy, 1);
        if (ms == M_ADD && mode != 2) begin
            if (mode == 1) begin
                @(negedge clock);
                bus.enter = 1'b1;
                @(negedge clock);
                bus.enter = 1'b0;
            end
            for (int k = 0; k < 20; k++) begin
                #1;
                if (done_cnt != start) break;
                @(negedge clock);
            end
            check("done_seen", done_cnt - start, 1);
            ms = M_SHOW;
            @(negedge clock);
            #1;
            check("done_one_cycle", bus.done, 0);
            check("state_show_hold", bus.state_out, 3);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a"},     bus.a_out, 0);
        check({tag, "_b"},     bus.b_out, 0);
        check({tag, "_sum"},   bus.sum_out, 0);
        check({tag, "_carry"}, bus.carry_out, 0);
        check({tag, "_busy"},  bus.busy, 0);
        check({tag, "_done"},  bus.done, 0);
        check({tag, "_state"}, bus.state_out, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        reset        = 1'b1;
        bus.enter    = 1'b0;
        bus.acc_mode = 1'b0;
        bus.sw       = '0;
        model_reset();
        repeat (2) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;

        // Basic add, accumulate, then overflow across the nibble boundary.
        drive_press(8'h3C, 0, 0);
        drive_press(8'h25, 0, 0);
        drive_press(8'h10, 1, 0);
        drive_press(8'hFF, 0, 0);
        drive_press(8'h01, 0, 0);

        // A press while the add is running must be ignored.
        drive_press(8'hAA, 0, 0);
        drive_press(8'h55, 0, 1);

        for (int i = 0; i < 40; i++) begin
            drive_press(int'($urandom_range(0, 255)), int'($urandom_range(0, 1)),
                        ($urandom_range(0, 3) == 0) ? 1 : 0);
        end

        // Reset one cycle into ADD discards the partial result.
        if (ms == M_A) drive_press(int'($urandom_range(0, 255)), 0, 0);
        drive_press(8'h9E, 1, 2);
        start = done_cnt;
        @(negedge clock);
        check("state_mid_add", bus.state_out, 2);
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        model_reset();
        repeat (3) @(negedge clock);
        check("no_done_after_reset", done_cnt - start, 0);
        reset = 1'b0;

        // Held button in LOAD_A: one load only, sw wiggling afterwards is ignored.
        @(negedge clock);
        bus.sw    = 8'h5A;
        bus.enter = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            bus.sw = W'($urandom_range(0, 255));
        end
        check("held_a", bus.a_out, 8'h5A);
        check("held_b", bus.b_out, 0);
        check("held_state", bus.state_out, 1);
        bus.enter = 1'b0;
        ma = 8'h5A;
        ms = M_B;
        drive_press(8'h33, 0, 0);

        repeat (3) @(negedge clock);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
